// File: rtl/byte_serial_pkg.sv
// Shared types and line-level constants for the byte-serial link
// (transmitter and receiver).
package byte_serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam int   FRAME_DATA_BITS = 8;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Even parity: the returned bit makes the total count of 1s even.
    function automatic logic even_parity(input logic [FRAME_DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/byte_serial_tx_if.sv
// Parallel byte handshake between a producer and the serial transmitter.
interface byte_serial_tx_if;
    import byte_serial_pkg::*;

    logic [FRAME_DATA_BITS-1:0] data_in;
    logic                       valid;
    logic                       ready;

    modport master (output data_in, output valid, input  ready);
    modport slave  (input  data_in, input  valid, output ready);

endinterface

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts 0..DIV-1 and flags the last cycle of each bit.
// The receiver reuses it, releasing `clear` at a mid-bit offset.
module serial_bit_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rstb,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    if (DIV < 1) begin : g_bad_div
        $error("serial_bit_timer: DIV must be at least 1");
    end

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: hold at zero while cleared, otherwise wrap at LAST.
    always_comb begin
        // NOTE: default assigned first so every path drives count_d; no latch is inferred.
        count_d = count_q + CNT_W'(1);
        if (clear || (count_q == LAST)) begin
            count_d = '0;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop updates from pre-edge values.
        if (!rstb) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/byte_serial_tx.sv
// Parallel-to-serial byte transmitter: start bit, 8 data bits LSB first,
// optional even parity, stop bit. Idle line is high; all outputs registered.
module byte_serial_tx
    import byte_serial_pkg::*;
#(
    parameter int DIV       = 4,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rstb,
    byte_serial_tx_if.slave  bus,
    output logic             txd,
    output logic             busy
);

    state_e                     state_q,   state_d;
    logic [FRAME_DATA_BITS-1:0] shreg_q,   shreg_d;
    logic [2:0]                 bit_idx_q, bit_idx_d;
    logic                       parity_q,  parity_d;
    logic                       txd_q,     txd_d;
    logic                       ready_q,   ready_d;
    logic                       busy_q,    busy_d;
    logic                       bit_tick;

    // Bit timer is held at zero while idle so the start bit gets a full period.
    serial_bit_timer #(.DIV(DIV)) u_timer (
        .clk   (clk),
        .rstb  (rstb),
        .clear (state_q == IDLE),
        .tick  (bit_tick)
    );

    // Next-state and next-output logic; outputs change only at bit boundaries.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        txd_d     = txd_q;
        ready_d   = ready_q;
        busy_d    = busy_q;

        unique case (state_q)
            IDLE: begin
                // data_in is only looked at here, so X outside a handshake never reaches txd.
                if (bus.valid && ready_q) begin
                    state_d  = START;
                    shreg_d  = bus.data_in;
                    parity_d = even_parity(bus.data_in);
                    txd_d    = START_LEVEL;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    txd_d     = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == 3'(FRAME_DATA_BITS - 1)) begin
                        if (PARITY_EN) begin
                            state_d = PARITY;
                            txd_d   = parity_q;
                        end else begin
                            state_d = STOP;
                            txd_d   = STOP_LEVEL;
                        end
                    end else begin
                        txd_d     = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                    txd_d   = STOP_LEVEL;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_d = IDLE;
                    txd_d   = IDLE_LEVEL;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = IDLE_LEVEL;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            // NOTE: datapath flops are reset too so nothing stale or X survives reset.
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            txd_q     <= IDLE_LEVEL;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            txd_q     <= txd_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.ready = ready_q;
    assign txd       = txd_q;
    assign busy      = busy_q;

endmodule
